// File: rtl/logicnets_pkg.sv
// Shared state encoding and sizing helpers for the LogicNets LUT layer.
package logicnets_pkg;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StWrite
    } state_e;

    function automatic int unsigned table_depth(input int unsigned fan_in);
        return 32'd1 << fan_in;
    endfunction

    // One spare code so an out-of-range neuron index can be expressed on the cfg port.
    function automatic int unsigned neuron_idx_w(input int unsigned n_neurons);
        return $clog2(n_neurons + 1);
    endfunction

endpackage

// File: rtl/logicnets_lut_neuron.sv
// One truth-table neuron: register table cleared at reset, single write port,
// combinational lookup.
module logicnets_lut_neuron
    import logicnets_pkg::*;
#(
    parameter int unsigned FAN_IN   = 6,
    parameter int unsigned OUT_BITS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [FAN_IN-1:0]   addr,
    input  logic [OUT_BITS-1:0] data,
    input  logic [FAN_IN-1:0]   lookup_addr,
    output logic [OUT_BITS-1:0] lookup_data
);

    localparam int unsigned DEPTH = table_depth(FAN_IN);

    logic [OUT_BITS-1:0] tbl_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (we) begin
            tbl_q[addr] <= data;
        end
    end

    assign lookup_data = tbl_q[lookup_addr];

endmodule

// File: rtl/logicnets_lut_layer_pipe.sv
// Two-stage pipelined LogicNets layer with valid/ready streaming and a config port
// that drains the pipe before rewriting table entries.
module logicnets_lut_layer_pipe
    import logicnets_pkg::*;
#(
    parameter int unsigned N_NEURONS = 8,
    parameter int unsigned FAN_IN    = 6,
    parameter int unsigned OUT_BITS  = 1,
    localparam int unsigned IDX_W    = neuron_idx_w(N_NEURONS),
    localparam int unsigned IN_W     = N_NEURONS * FAN_IN,
    localparam int unsigned OUT_W    = N_NEURONS * OUT_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [IDX_W-1:0]    cfg_neuron,
    input  logic [FAN_IN-1:0]   cfg_addr,
    input  logic [OUT_BITS-1:0] cfg_data
);

    state_e           state_q, state_d;
    logic             s1_valid_q, s2_valid_q;
    logic [IN_W-1:0]  s1_data_q;
    logic [OUT_W-1:0] s2_data_q;
    logic [OUT_W-1:0] lut_out;
    logic             s1_en, s2_en, tbl_we, in_fire;

    assign s2_en     = !s2_valid_q || out_ready;
    assign s1_en     = !s1_valid_q || s2_en;
    assign in_ready  = s1_en && (state_q == StRun);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (s1_en) begin
                s1_valid_q <= in_fire;
                if (in_fire) begin
                    s1_data_q <= in_data;
                end
            end
            if (s2_en) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= lut_out;
                end
            end
        end
    end

    // WRITE stays resident while cfg_valid is held so bursts retire one entry per cycle.
    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        tbl_we    = 1'b0;
        unique case (state_q)
            StRun: begin
                if (cfg_valid) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!cfg_valid) begin
                    state_d = StRun;
                end else if (!s1_valid_q && !s2_valid_q) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (cfg_valid) begin
                    cfg_ready = 1'b1;
                    tbl_we    = 1'b1;
                end else begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
        logicnets_lut_neuron #(
            .FAN_IN  (FAN_IN),
            .OUT_BITS(OUT_BITS)
        ) u_neuron (
            .clk        (clk),
            .rst_n      (rst_n),
            .we         (tbl_we && (cfg_neuron == IDX_W'(n))),
            .addr       (cfg_addr),
            .data       (cfg_data),
            .lookup_addr(s1_data_q[n*FAN_IN +: FAN_IN]),
            .lookup_data(lut_out[n*OUT_BITS +: OUT_BITS])
        );
    end

endmodule

// File: tb/tb_logicnets_lut_layer_pipe.sv
// Randomised bench for the LUT layer: scoreboard against a per-neuron table model.
module tb_logicnets_lut_layer_pipe;

    localparam int N     = 8;
    localparam int FI    = 6;
    localparam int OB    = 1;
    localparam int IN_W  = N * FI;
    localparam int OUT_W = N * OB;
    localparam int IDX_W = 4;
    localparam int DEPTH = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [IDX_W-1:0] cfg_neuron = '0;
    logic [FI-1:0]    cfg_addr = '0;
    logic [OB-1:0]    cfg_data = '0;

    int n_checks = 0;
    int n_errors = 0;
    int ov_run = 0;
    int ov_max = 0;

    logic [OB-1:0]    model [N][DEPTH];
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] got_q[$];
    logic [IN_W-1:0]  beats[$];
    logic [IDX_W-1:0] bn[$];
    logic [FI-1:0]    ba[$];
    logic [OB-1:0]    bd[$];

    always #5 clk = ~clk;

    logicnets_lut_layer_pipe #(
        .N_NEURONS(N),
        .FAN_IN   (FI),
        .OUT_BITS (OB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_neuron(cfg_neuron),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data)
    );

    function automatic logic [OUT_W-1:0] ref_layer(input logic [IN_W-1:0] x);
        logic [OUT_W-1:0] y;
        for (int n = 0; n < N; n++) y[n*OB +: OB] = model[n][x[n*FI +: FI]];
        return y;
    endfunction

    function automatic logic [IN_W-1:0] rnd_beat();
        return IN_W'({$urandom(), $urandom()});
    endfunction

    // Handshakes observed mid-cycle complete at the following rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            got_q.delete();
            ov_run = 0;
            for (int n = 0; n < N; n++)
                for (int a = 0; a < DEPTH; a++) model[n][a] = '0;
        end else begin
            if (in_valid && in_ready) exp_q.push_back(ref_layer(in_data));
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                ov_run++;
                if (ov_run > ov_max) ov_max = ov_run;
            end else begin
                ov_run = 0;
            end
            if (cfg_valid && cfg_ready && int'(cfg_neuron) < N) model[cfg_neuron][cfg_addr] = cfg_data;
        end
    end

    task automatic settle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic cfg_burst(output int ready_cycles, output int max_run);
        int idx = 0;
        int guard = 0;
        int run = 0;
        ready_cycles = 0;
        max_run = 0;
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_neuron = bn[0]; cfg_addr = ba[0]; cfg_data = bd[0];
        while (idx < bn.size() && guard < 200) begin
            @(negedge clk);
            guard++;
            if (cfg_ready) begin
                ready_cycles++; run++; idx++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            @(posedge clk); #1;
            if (idx < bn.size()) begin
                cfg_neuron = bn[idx]; cfg_addr = ba[idx]; cfg_data = bd[idx];
            end else begin
                cfg_valid = 1'b0;
            end
        end
        n_checks++;
        if (idx != bn.size()) begin
            n_errors++;
            $display("FAIL cfg_timeout: accepted %0d writes, required %0d", idx, bn.size());
        end
        cfg_valid = 1'b0;
        bn.delete(); ba.delete(); bd.delete();
        @(posedge clk); #1;
    endtask

    task automatic send_beats(input int valid_pct, input int ready_pct);
        int guard = 0;
        bit taken = 0;
        while (guard < 5000) begin
            @(posedge clk); #1;
            guard++;
            if (taken) begin void'(beats.pop_front()); taken = 0; in_valid = 1'b0; end
            if (beats.size() == 0) break;
            out_ready = ($urandom_range(99) < ready_pct);
            if (!in_valid && $urandom_range(99) < valid_pct) begin
                in_valid = 1'b1; in_data = beats[0];
            end
            @(negedge clk);
            taken = in_valid && in_ready;
        end
        n_checks++;
        if (beats.size() != 0) begin
            n_errors++;
            $display("FAIL stream_timeout: %0d beats left, required 0", beats.size());
        end
        beats.delete();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || cfg_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: out_valid=%b out_data=%h cfg_ready=%b, required 0/0/0",
                     out_valid, out_data, cfg_ready);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_latency();
        logic [IN_W-1:0] d;
        int rc, mr;
        bn.push_back(IDX_W'(0)); ba.push_back(6'b001000); bd.push_back(1'b1);
        cfg_burst(rc, mr);
        d = rnd_beat();
        d[FI-1:0] = 6'b001000;
        out_ready = 1'b1; in_valid = 1'b1; in_data = d;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL lat_accept: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL lat_early: out_valid=%b one cycle after accept, required 0", out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL lat_out: out_valid=%b bit0=%b two cycles after accept, required 1/1",
                     out_valid, out_data[0]);
        end
        @(posedge clk); #1;
        settle();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_errors++; $display("FAIL lat_count: got %0d beats, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errors++; $display("FAIL lat_data[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_stall();
        logic [IN_W-1:0]  b [3];
        logic [OUT_W-1:0] held = '0;
        bit have = 0;
        int acc = 0;
        int unstable = 0;
        int guard = 0;
        for (int i = 0; i < 3; i++) b[i] = rnd_beat();
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_data = b[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (!have) begin held = out_data; have = 1; end
                else if (out_data !== held) unstable++;
            end
            if (in_ready) acc++;
            @(posedge clk); #1;
            if (acc < 3) in_data = b[acc];
            else in_valid = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (acc != 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_hold: accepted=%0d in_ready=%b out_valid=%b, required 2/0/1",
                     acc, in_ready, out_valid);
        end
        n_checks++;
        if (unstable != 0 || out_data !== held) begin
            n_errors++;
            $display("FAIL stall_stable: out_data=%h changed %0d times, required steady %h",
                     out_data, unstable, held);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        while (!(in_valid && in_ready) && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        settle();
        n_checks++;
        if (got_q.size() != 3 || exp_q.size() != 3) begin
            n_errors++;
            $display("FAIL stall_count: got %0d beats, model %0d, required 3", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errors++; $display("FAIL stall_data[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_cfg_drain();
        logic [IN_W-1:0] b0, b1, b2;
        logic [FI-1:0]   a;
        logic [OB-1:0]   nd;
        int guard = 0;
        b0 = rnd_beat(); a = b0[FI +: FI];
        b1 = rnd_beat(); b1[FI +: FI] = a;
        b2 = rnd_beat(); b2[FI +: FI] = a;
        nd = ~model[1][a];
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; in_data = b0;
        @(posedge clk); #1;
        in_data = b1; cfg_valid = 1'b1; cfg_neuron = IDX_W'(1); cfg_addr = a; cfg_data = nd;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL drain_same_cycle: in_ready=%b with cfg request, required 1", in_ready);
        end
        @(posedge clk); #1 in_data = b2;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || cfg_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_block: in_ready=%b cfg_ready=%b, required 0/0", in_ready, cfg_ready);
        end
        while (!cfg_ready && guard < 50) begin @(negedge clk); guard++; end
        n_checks++;
        if (cfg_ready !== 1'b1 || got_q.size() != 2) begin
            n_errors++;
            $display("FAIL drain_order: cfg_ready=%b after %0d beats out, required 1 after 2",
                     cfg_ready, got_q.size());
        end
        @(posedge clk); #1 cfg_valid = 1'b0;
        guard = 0;
        while (!(in_valid && in_ready) && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        settle();
        n_checks++;
        if (got_q.size() != 3 || exp_q.size() != 3) begin
            n_errors++;
            $display("FAIL drain_count: got %0d beats, model %0d, required 3", got_q.size(), exp_q.size());
        end else begin
            n_checks++;
            if (got_q[2][1] !== nd || got_q[0][1] !== ~nd || got_q[1][1] !== ~nd) begin
                n_errors++;
                $display("FAIL drain_tables: bit1 of beats = %b %b %b, required %b %b %b",
                         got_q[0][1], got_q[1][1], got_q[2][1], ~nd, ~nd, nd);
            end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errors++; $display("FAIL drain_data[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) beats.push_back(rnd_beat());
        ov_max = 0;
        send_beats(100, 100);
        settle();
        n_checks++;
        if (ov_max != 16 || got_q.size() != 16) begin
            n_errors++;
            $display("FAIL b2b_throughput: longest output run %0d of %0d beats, required 16 of 16",
                     ov_max, got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errors++; $display("FAIL b2b_data[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_cfg_burst();
        int wn [4];
        logic [FI-1:0] wa [4];
        logic [OB-1:0] wd [4];
        logic [IN_W-1:0] b;
        int rc, mr;
        for (int i = 0; i < 4; i++) begin
            wn[i] = $urandom_range(N - 1);
            wa[i] = FI'(i * 16 + $urandom_range(15));
            wd[i] = ~model[wn[i]][wa[i]];
            bn.push_back(IDX_W'(wn[i])); ba.push_back(wa[i]); bd.push_back(wd[i]);
        end
        cfg_burst(rc, mr);
        n_checks++;
        if (rc != 4 || mr != 4) begin
            n_errors++;
            $display("FAIL burst_ready: %0d ready cycles, longest run %0d, required 4/4", rc, mr);
        end
        for (int i = 0; i < 4; i++) begin
            b = rnd_beat();
            b[wn[i]*FI +: FI] = wa[i];
            beats.push_back(b);
        end
        send_beats(100, 100);
        settle();
        n_checks++;
        if (got_q.size() != 4) begin
            n_errors++; $display("FAIL burst_count: got %0d beats, required 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i][wn[i]] !== wd[i]) begin
                n_errors++;
                $display("FAIL burst_readback[%0d]: neuron %0d entry %0d = %b, required %b",
                         i, wn[i], wa[i], got_q[i][wn[i]], wd[i]);
            end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errors++; $display("FAIL burst_data[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random_stream();
        logic [FI-1:0] wa [N];
        logic [IN_W-1:0] b;
        int rc, mr;
        for (int n = 0; n < N; n++) begin
            wa[n] = FI'($urandom_range(DEPTH - 1));
            bn.push_back(IDX_W'(n)); ba.push_back(wa[n]); bd.push_back(OB'($urandom_range(1)));
        end
        cfg_burst(rc, mr);
        for (int k = 0; k < 40; k++) begin
            b = rnd_beat();
            for (int n = 0; n < N; n++) if ($urandom_range(1) == 1) b[n*FI +: FI] = wa[n];
            beats.push_back(b);
        end
        send_beats(60, 70);
        settle();
        n_checks++;
        if (got_q.size() != 40 || exp_q.size() != 40) begin
            n_errors++;
            $display("FAIL rand_count: got %0d beats, model %0d, required 40", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errors++; $display("FAIL rand_data[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_invalid_neuron();
        logic [FI-1:0] a;
        logic [FI-1:0] k6;
        int rc, mr;
        a = FI'($urandom_range(DEPTH - 1));
        bn.push_back(IDX_W'(N)); ba.push_back(a); bd.push_back(~model[0][a]);
        cfg_burst(rc, mr);
        n_checks++;
        if (rc != 1) begin
            n_errors++; $display("FAIL invalid_ready: %0d ready cycles, required 1", rc);
        end
        for (int k = 0; k < DEPTH; k++) begin
            k6 = FI'(k);
            beats.push_back({N{k6}});
        end
        send_beats(70, 80);
        settle();
        n_checks++;
        if (got_q.size() != DEPTH || exp_q.size() != DEPTH) begin
            n_errors++;
            $display("FAIL invalid_count: got %0d beats, model %0d, required %0d",
                     got_q.size(), exp_q.size(), DEPTH);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errors++; $display("FAIL invalid_sweep[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_stream();
        logic [FI-1:0]   a;
        logic [IN_W-1:0] d;
        int rc, mr;
        a = FI'($urandom_range(DEPTH - 1));
        bn.push_back(IDX_W'(5)); ba.push_back(a); bd.push_back(1'b1);
        cfg_burst(rc, mr);
        d = rnd_beat();
        d[5*FI +: FI] = a;
        out_ready = 1'b1; in_valid = 1'b1; in_data = d;
        @(negedge clk);
        @(posedge clk); #1 in_data = rnd_beat();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data[5] !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_pre: out_valid=%b bit5=%b, required 1/1", out_valid, out_data[5]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            n_errors++;
            $display("FAIL rst_immediate: out_valid=%b out_data=%h, required 0/0", out_valid, out_data);
        end
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        in_valid = 1'b1; in_data = d;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL rst_accept: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== '0) begin
            n_errors++;
            $display("FAIL rst_tables: out_valid=%b out_data=%h, required 1/00", out_valid, out_data);
        end
        @(posedge clk); #1;
        settle();
        n_checks++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            n_errors++;
            $display("FAIL rst_count: got %0d beats, model %0d, required 1", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errors++; $display("FAIL rst_data[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_cfg_drain();
        test_back_to_back();
        test_cfg_burst();
        test_random_stream();
        test_invalid_neuron();
        test_reset_mid_stream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
